sprite_pixel_compositor: RTL and testbench
==========================================

// Module: sprite_pixel_compositor
// PURPOSE
//  Per-pixel compositor directly downstream of the image/mask store. Takes the static tile masks
//  plus the current VGA pixel coordinate, map tile type and sprite positions, and emits one 12-bit
//  RGB pixel per clock to the VGA output stage. It owns the animation-frame and frightened-blink
//  timers, which are frame-synchronous.
// PARAMETERS
//  TILE         16     tile edge in pixels; every mask input is TILE*TILE bits, bit index row*TILE+col
//  ANIM_FRAMES  8      video frames per animation phase (f1 <-> f2)
//  BLINK_FRAMES 16     video frames per frightened-blink phase
//  GHOST_RGB    12'hF00  normal ghost body colour {r,g,b}
// PORTS
//  clk                  in   1        system clock
//  rst_n                in   1        synchronous reset, active low
//  pixel_x, pixel_y     in   10 each  current pixel coordinate
//  pixel_valid          in   1        pixel is inside the active area
//  frame_start          in   1        one-cycle pulse per video frame
//  tile_type            in   2        map tile under the pixel: 0 empty, 1 wall, 2 dot, 3 big dot
//  tile_col, tile_row   in   log2(TILE) each  pixel offset inside its map tile
//  player_x, player_y   in   10 each  player sprite top-left, in pixels
//  ghost_x, ghost_y     in   10 each  ghost sprite top-left, in pixels
//  ghost_dir            in   2        0 up, 1 down, 2 left, 3 right
//  ghost_frightened     in   1        ghost is in frightened (void) mode
//  fright_ending        in   1        frightened mode is about to expire; enables blinking
//  player_mask_f1/f2, ghost_mask_f1/f2, dot_mask, big_dot_mask,
//  ghost_void_mask_f1/f2, ghost_void_face_mask   in  TILE*TILE each  static masks
//  ghost_sclera_mask, ghost_eye_mask  in  4*TILE*TILE  {right,left,down,up}, concatenated in that order
//  vga_r, vga_g, vga_b  out  4 each   composited colour, registered
//  out_valid            out  1        vga_* correspond to a pixel_valid input 2 cycles earlier
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): vga_r/g/b=0, out_valid=0, both pipeline valid bits=0,
//   anim_cnt=0, anim_phase=0 (f1), blink_cnt=0, blink_phase=0. Reset mid-line drops in-flight pixels.
//  Pipeline: 2 stages, fixed latency 2, no stalls, throughput 1 pixel/clk.
//   S1 registers: pdx=pixel_x-player_x and pdy (10-bit modular), gdx/gdy likewise, tile_type,
//    tile_col/tile_row, ghost state, pixel_valid.
//    in_player = (pdx<TILE)&&(pdy<TILE); in_ghost likewise. Negative differences wrap to a large
//    value and therefore fall outside; sprites at the screen edge clip correctly.
//   S2 registers vga_* and out_valid. Index = dy*TILE+dx. Priority, highest first:
//    1 player: yellow F,F,0 if active player mask bit (f1/f2 chosen by anim_phase)
//    2 ghost frightened: face mask -> F,F,F; else void mask (anim_phase) -> body 0,0,F,
//      or F,F,F when fright_ending && blink_phase
//    3 ghost normal: eye[dir] -> 0,0,F; else sclera[dir] -> F,F,F; else body mask -> GHOST_RGB
//    4 tile 2/3: dot/big_dot mask bit at (tile_row,tile_col) -> F,B,9
//    5 tile 1: wall 0,0,F
//    6 otherwise background 0,0,0
//   A clear mask bit falls through to the next priority level.
//   If S1 valid=0, S2 drives vga_*=0 and out_valid=0.
//  Timers advance only on frame_start:
//   anim_cnt counts 0..ANIM_FRAMES-1; at the wrap anim_phase toggles.
//   blink_cnt counts 0..BLINK_FRAMES-1; at the wrap blink_phase toggles.
//   blink_cnt/blink_phase are held at 0 while fright_ending=0.
//   A phase change on frame_start applies to pixels entering S1 on the following cycle.
//   frame_start coincident with pixel_valid is legal; that pixel uses the old phase.
//  ghost_dir and the frightened inputs are sampled per pixel in S1; mid-frame changes take effect
//   at the next pixel.
// TESTING
//  T1 reset: hold rst_n=0 with pixel_valid=1 -> vga=0, out_valid=0; release -> first out_valid 2 clks later
//  T2 priority: player and ghost both at (100,100), pixel (108,108), player bit=1 -> F,F,0;
//     player bit=0 and ghost body bit=1 -> F,0,0
//  T3 clipping: player_x=1020, pixel_x=2 (dx=6 via wrap) -> sprite drawn; pixel_x=1019 -> not drawn
//  T4 animation: ANIM_FRAMES=8 -> mask switches f1->f2 after exactly 8 frame_start pulses and back after 16
//  T5 blink: frightened with fright_ending=1 -> body alternates 0,0,F / F,F,F every 16 frames;
//     fright_ending=0 -> stays 0,0,F
//  T6 tiles: tile_type=1 -> 0,0,F; tile_type=2 with dot bit=0 -> 0,0,0; pixel_valid=0 -> out_valid=0, vga=0

Source files
------------

// File: rtl/sprite_pixel_compositor.sv
// sprite_pixel_compositor: two-stage per-pixel sprite/tile compositor with frame-synchronous animation and blink timers
module sprite_pixel_compositor #(
  parameter int TILE = 16,
  parameter int ANIM_FRAMES = 8,
  parameter int BLINK_FRAMES = 16,
  parameter logic [11:0] GHOST_RGB = 12'hF00
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [9:0]                pixel_x,
  input  logic [9:0]                pixel_y,
  input  logic                      pixel_valid,
  input  logic                      frame_start,
  input  logic [1:0]                tile_type,
  input  logic [$clog2(TILE)-1:0]   tile_col,
  input  logic [$clog2(TILE)-1:0]   tile_row,
  input  logic [9:0]                player_x,
  input  logic [9:0]                player_y,
  input  logic [9:0]                ghost_x,
  input  logic [9:0]                ghost_y,
  input  logic [1:0]                ghost_dir,
  input  logic                      ghost_frightened,
  input  logic                      fright_ending,
  input  logic [TILE*TILE-1:0]      player_mask_f1,
  input  logic [TILE*TILE-1:0]      player_mask_f2,
  input  logic [TILE*TILE-1:0]      ghost_mask_f1,
  input  logic [TILE*TILE-1:0]      ghost_mask_f2,
  input  logic [TILE*TILE-1:0]      dot_mask,
  input  logic [TILE*TILE-1:0]      big_dot_mask,
  input  logic [TILE*TILE-1:0]      ghost_void_mask_f1,
  input  logic [TILE*TILE-1:0]      ghost_void_mask_f2,
  input  logic [TILE*TILE-1:0]      ghost_void_face_mask,
  input  logic [4*TILE*TILE-1:0]    ghost_sclera_mask,
  input  logic [4*TILE*TILE-1:0]    ghost_eye_mask,
  output logic [3:0]                vga_r,
  output logic [3:0]                vga_g,
  output logic [3:0]                vga_b,
  output logic                      out_valid
);
  localparam int TW = $clog2(TILE);
  localparam int AW = $clog2(ANIM_FRAMES);
  localparam int BW = $clog2(BLINK_FRAMES);
  logic [AW-1:0] anim_cnt;
  logic [BW-1:0] blink_cnt;
  logic anim_phase, blink_phase;
  logic s1_valid, s1_fr, s1_fe, s1_anim, s1_blink;
  logic [9:0] pdx, pdy, gdx, gdy;
  logic [1:0] s1_tile, s1_dir;
  logic [TW-1:0] s1_col, s1_row;
  logic [2*TW-1:0] p_idx, g_idx, t_idx;
  logic in_player, in_ghost, player_hit, body_hit, void_hit, face_hit, eye_hit, sclera_hit, dot_hit;
  logic [11:0] tile_rgb, fr_rgb, normal_rgb, rgb;
  always_ff @(posedge clk)
    if (!rst_n) begin
      anim_cnt <= '0;
      anim_phase <= 1'b0;
      blink_cnt <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (frame_start) begin
        anim_cnt <= anim_cnt == AW'(ANIM_FRAMES-1) ? '0 : anim_cnt + 1'b1;
        if (anim_cnt == AW'(ANIM_FRAMES-1)) anim_phase <= !anim_phase;
      end
      if (!fright_ending) begin
        blink_cnt <= '0;
        blink_phase <= 1'b0;
      end else if (frame_start) begin
        blink_cnt <= blink_cnt == BW'(BLINK_FRAMES-1) ? '0 : blink_cnt + 1'b1;
        if (blink_cnt == BW'(BLINK_FRAMES-1)) blink_phase <= !blink_phase;
      end
    end
  always_ff @(posedge clk)
    s1_valid <= rst_n && pixel_valid;
  // S1 captures the phase registers before this edge's update, so a pixel coincident with frame_start keeps the old phase
  always_ff @(posedge clk) begin
    pdx <= pixel_x - player_x;
    pdy <= pixel_y - player_y;
    gdx <= pixel_x - ghost_x;
    gdy <= pixel_y - ghost_y;
    s1_tile <= tile_type;
    s1_col <= tile_col;
    s1_row <= tile_row;
    s1_dir <= ghost_dir;
    s1_fr <= ghost_frightened;
    s1_fe <= fright_ending;
    s1_anim <= anim_phase;
    s1_blink <= blink_phase;
  end
  always_comb begin
    p_idx = {pdy[TW-1:0], pdx[TW-1:0]};
    g_idx = {gdy[TW-1:0], gdx[TW-1:0]};
    t_idx = {s1_row, s1_col};
    in_player = pdx < 10'(TILE) && pdy < 10'(TILE);
    in_ghost = gdx < 10'(TILE) && gdy < 10'(TILE);
    player_hit = in_player && (s1_anim ? player_mask_f2[p_idx] : player_mask_f1[p_idx]);
    body_hit = s1_anim ? ghost_mask_f2[g_idx] : ghost_mask_f1[g_idx];
    void_hit = s1_anim ? ghost_void_mask_f2[g_idx] : ghost_void_mask_f1[g_idx];
    face_hit = ghost_void_face_mask[g_idx];
    eye_hit = ghost_eye_mask[{s1_dir, g_idx}];
    sclera_hit = ghost_sclera_mask[{s1_dir, g_idx}];
    dot_hit = (s1_tile == 2'd2 && dot_mask[t_idx]) || (s1_tile == 2'd3 && big_dot_mask[t_idx]);
    tile_rgb = dot_hit ? 12'hFB9 : s1_tile == 2'd1 ? 12'h00F : 12'h000;
    fr_rgb = face_hit ? 12'hFFF : void_hit ? (s1_fe && s1_blink ? 12'hFFF : 12'h00F) : tile_rgb;
    normal_rgb = eye_hit ? 12'h00F : sclera_hit ? 12'hFFF : body_hit ? GHOST_RGB : tile_rgb;
    rgb = !s1_valid ? 12'h000 : player_hit ? 12'hFF0 : !in_ghost ? tile_rgb : s1_fr ? fr_rgb : normal_rgb;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      out_valid <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= rgb;
      out_valid <= s1_valid;
    end
endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// tb_sprite_pixel_compositor: directed vectors with hand-computed colours for the sprite compositor
module tb_sprite_pixel_compositor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, pixel_valid, frame_start, ghost_frightened, fright_ending, out_valid;
  logic [9:0] pixel_x, pixel_y, player_x, player_y, ghost_x, ghost_y;
  logic [1:0] tile_type, ghost_dir;
  logic [3:0] tile_col, tile_row, vga_r, vga_g, vga_b;
  logic [255:0] player_mask_f1, player_mask_f2, ghost_mask_f1, ghost_mask_f2, dot_mask, big_dot_mask;
  logic [255:0] ghost_void_mask_f1, ghost_void_mask_f2, ghost_void_face_mask;
  logic [1023:0] ghost_sclera_mask, ghost_eye_mask;
  int checks = 0, errors = 0;
  sprite_pixel_compositor dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .tile_type(tile_type), .tile_col(tile_col), .tile_row(tile_row),
    .player_x(player_x), .player_y(player_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
    .ghost_dir(ghost_dir), .ghost_frightened(ghost_frightened), .fright_ending(fright_ending),
    .player_mask_f1(player_mask_f1), .player_mask_f2(player_mask_f2),
    .ghost_mask_f1(ghost_mask_f1), .ghost_mask_f2(ghost_mask_f2),
    .dot_mask(dot_mask), .big_dot_mask(big_dot_mask),
    .ghost_void_mask_f1(ghost_void_mask_f1), .ghost_void_mask_f2(ghost_void_mask_f2),
    .ghost_void_face_mask(ghost_void_face_mask),
    .ghost_sclera_mask(ghost_sclera_mask), .ghost_eye_mask(ghost_eye_mask),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .out_valid(out_valid)
  );
  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic show(input string tag, input logic [12:0] exp);
    tick();
    tick();
    check(tag, {out_valid, vga_r, vga_g, vga_b}, exp);
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
  endtask
  initial begin
    rst_n = 1'b0; pixel_valid = 1'b1; frame_start = 1'b0;
    pixel_x = 10'd0; pixel_y = 10'd0; tile_type = 2'd1; tile_col = 4'd0; tile_row = 4'd0;
    player_x = 10'd600; player_y = 10'd600; ghost_x = 10'd500; ghost_y = 10'd500;
    ghost_dir = 2'd0; ghost_frightened = 1'b0; fright_ending = 1'b0;
    player_mask_f1 = '0; player_mask_f2 = '0; ghost_mask_f1 = '0; ghost_mask_f2 = '0;
    dot_mask = '0; big_dot_mask = '0; ghost_void_mask_f1 = '0; ghost_void_mask_f2 = '0;
    ghost_void_face_mask = '0; ghost_sclera_mask = '0; ghost_eye_mask = '0;
    repeat (3) tick();
    check("rst_hold", {out_valid, vga_r, vga_g, vga_b}, 13'h0000);
    rst_n = 1'b1;
    tick();
    check("rst_lat1", {out_valid, vga_r, vga_g, vga_b}, 13'h0000);
    tick();
    check("rst_lat2", {out_valid, vga_r, vga_g, vga_b}, 13'h100F);
    tile_type = 2'd0;
    player_x = 10'd100; player_y = 10'd100; ghost_x = 10'd100; ghost_y = 10'd100;
    pixel_x = 10'd108; pixel_y = 10'd108;
    player_mask_f1[136] = 1'b1; ghost_mask_f1[136] = 1'b1;
    show("prio_player", 13'h1FF0);
    player_mask_f1[136] = 1'b0;
    show("prio_ghost", 13'h1F00);
    ghost_eye_mask[136] = 1'b1;
    show("eye_up", 13'h100F);
    ghost_dir = 2'd2; ghost_sclera_mask[512+136] = 1'b1;
    show("sclera_left", 13'h1FFF);
    ghost_mask_f1 = '0; ghost_sclera_mask = '0; ghost_eye_mask = '0; tile_type = 2'd1;
    show("ghost_clear_wall", 13'h100F);
    ghost_x = 10'd500; ghost_y = 10'd500; ghost_dir = 2'd0; tile_type = 2'd0;
    player_x = 10'd1020; player_y = 10'd0; pixel_x = 10'd2; pixel_y = 10'd0;
    player_mask_f1[6] = 1'b1;
    show("clip_wrap", 13'h1FF0);
    pixel_x = 10'd1019;
    show("clip_left", 13'h1000);
    player_mask_f1 = '0; player_mask_f1[0] = 1'b1;
    player_x = 10'd0; player_y = 10'd0; pixel_x = 10'd0; pixel_y = 10'd0; tile_type = 2'd1;
    frames(7);
    show("anim7", 13'h1FF0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    check("anim8_coincident", {out_valid, vga_r, vga_g, vga_b}, 13'h1FF0);
    tick();
    check("anim8", {out_valid, vga_r, vga_g, vga_b}, 13'h100F);
    frames(7);
    show("anim15", 13'h100F);
    frames(1);
    show("anim16", 13'h1FF0);
    player_x = 10'd600; player_y = 10'd600; ghost_x = 10'd0; ghost_y = 10'd0;
    ghost_void_mask_f1[0] = 1'b1; ghost_void_mask_f2[0] = 1'b1; ghost_frightened = 1'b1;
    show("fr_body", 13'h100F);
    ghost_void_face_mask[0] = 1'b1;
    show("fr_face", 13'h1FFF);
    ghost_void_face_mask[0] = 1'b0;
    frames(16);
    show("no_blink", 13'h100F);
    fright_ending = 1'b1;
    frames(15);
    show("blink15", 13'h100F);
    frames(1);
    show("blink16", 13'h1FFF);
    frames(16);
    show("blink32", 13'h100F);
    frames(16);
    show("blink48", 13'h1FFF);
    fright_ending = 1'b0;
    show("blink_off", 13'h100F);
    ghost_x = 10'd500; ghost_y = 10'd500; ghost_frightened = 1'b0;
    tile_type = 2'd2; tile_col = 4'd3; tile_row = 4'd2;
    show("dot_clear", 13'h1000);
    dot_mask[35] = 1'b1;
    show("dot_set", 13'h1FB9);
    tile_type = 2'd3;
    show("big_clear", 13'h1000);
    big_dot_mask[35] = 1'b1;
    show("big_set", 13'h1FB9);
    tile_type = 2'd1; pixel_valid = 1'b0;
    show("invalid", 13'h0000);
    pixel_valid = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid", {out_valid, vga_r, vga_g, vga_b}, 13'h0000);
    rst_n = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
